eclk_bus_bridge: RTL and testbench
==================================

Name: eclk_bus_bridge

Overview:
- Responder for the E-clock phase enables produced by the master clock generator.
- Runs slow, synchronous 6800-style peripheral cycles, such as CIA accesses, on behalf of a CPU-side request.
- Aligns each access to the 10-phase E period, drives VMA, E and the peripheral strobe, captures read data at E fall, and returns a one-cycle acknowledge.
- Sits between the CPU bus glue and the CIA/6800-type peripherals, in the 7.09 MHz clk domain.

Parameters:
- DATA_W, 8, peripheral data width.
- SYNC_TIMEOUT, 31, max clk cycles spent waiting for phase 0 before abort. Range 10..255.

Ports:
- clk  input  1  7.09 MHz system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- eclk  input  10  E phase enables; eclk[n] high for exactly one clk cycle when the phase counter is n, so one-hot, period 10.
- req  input  1  CPU requests a peripheral cycle (level, held until ack or err).
- rnw  input  1  1 = read, 0 = write; sampled with req.
- wdata  input  DATA_W  write data; sampled with req.
- per_rdata  input  DATA_W  peripheral read data.
- vma  output  1  valid memory address, registered.
- e  output  1  E clock, registered; high during phases 6..9.
- per_sel  output  1  peripheral select, registered; high during phases 6..9 of the owned period.
- per_we  output  1  per_sel & ~rnw_latched.
- per_wdata  output  DATA_W  latched write data.
- rdata  output  DATA_W  captured read data; holds until the next read completes.
- ack  output  1  one-cycle pulse when a cycle completes.
- err  output  1  one-cycle pulse on sync timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0; latches 0.
- e: registered as e <= eclk[5]|eclk[6]|eclk[7]|eclk[8]. It is therefore high in the cycles where eclk[6..9] are high, which gives a 4-high/6-low duty.
- FSM states: IDLE, SYNC, WAIT_E, XFER, DONE, HOLD.
- IDLE:
  - On req, latch rnw and wdata.
  - If eclk[0]|eclk[1]|eclk[2] is high in that cycle, go to WAIT_E and set vma=1.
  - Otherwise go to SYNC and clear the timeout counter.
- SYNC:
  - If req drops, return to IDLE; no peripheral activity occurs.
  - On eclk[0], go to WAIT_E with vma=1.
  - Otherwise increment the counter. When the counter reaches SYNC_TIMEOUT, pulse err and go to HOLD.
- WAIT_E: vma=1. On eclk[5], go to XFER and set per_sel=1.
- XFER:
  - vma=1 and per_sel=1.
  - On eclk[9]: if rnw, capture per_rdata into rdata. Clear per_sel and vma, pulse ack, go to DONE.
- DONE: ack returns to 0; go to HOLD.
- HOLD: wait for req=0, then go to IDLE. A new cycle requires req to be low for at least one cycle.
- Abort rules:
  - Dropping req in WAIT_E or XFER does not abort; the cycle completes and ack still pulses.
  - Asynchronous reset in any state returns to IDLE immediately with all outputs 0. The partial cycle is lost and no ack is produced.
- Latency, measured from the req-sampled cycle to the ack cycle:
  - Phase p in 0..2: ack appears on the eclk[9] edge of the same period, i.e. 10-p cycles later.
  - Phase p in 3..9: one full period is skipped, giving (10-p)+10 cycles.
- Phase enables:
  - Multiple eclk bits high at once is illegal; behaviour follows the priority order of the checks above.
  - With no eclk activity, WAIT_E and XFER stall indefinitely. Only SYNC is guarded by the timeout.
- ack and err are never asserted together.
- per_wdata stays stable for the whole of XFER.

Test Plan:
- Reset mid-XFER (assert reset at phase 7) -> next cycle vma=per_sel=e=ack=0, state IDLE; after release, a new req completes normally.
- Read, req at phase 1, per_rdata=8'hA5 -> vma from phase 2; per_sel at phases 6..9; ack 9 cycles after req; rdata=8'hA5; e high exactly 4 of every 10 cycles.
- Write, req at phase 4, wdata=8'h3C -> SYNC; vma from phase 0 of the next period; per_we high during phases 6..9 of that period with per_wdata=8'h3C; ack 16 cycles after req.
- Req at phase 5, dropped after 2 cycles (in SYNC) -> no vma, no per_sel, no ack; state IDLE.
- Req at phase 1, dropped at phase 7 -> cycle completes; ack at phase 9; then HOLD passes straight to IDLE.
- Req at phase 4 with eclk held at 0 (SYNC_TIMEOUT=31) -> err pulses 31 cycles after entering SYNC; no ack; returns to IDLE once req is low.

Source files
------------

// File: rtl/eclk_bus_bridge.sv
// eclk_bus_bridge: runs 6800-style synchronous peripheral cycles (VMA/E/select)
// aligned to the 10-phase E period given by the one-hot eclk phase enables.
// A CPU-side request is held until a one-cycle ack (done) or err (timeout).
module eclk_bus_bridge #(
  parameter int DATA_W       = 8,
  parameter int SYNC_TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        eclk,
  input  logic              req,
  input  logic              rnw,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] per_rdata,
  output logic              vma,
  output logic              e,
  output logic              per_sel,
  output logic              per_we,
  output logic [DATA_W-1:0] per_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, SYNC, WAIT_E, XFER, DONE, HOLD} state_t;

  localparam logic [7:0] TIMEOUT = 8'(SYNC_TIMEOUT);

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic              vma_n, sel_n, ack_n, err_n;
  logic              rnw_l, rnw_l_n;
  logic [DATA_W-1:0] wdata_n, rdata_n;

  // Phases 3 and 4 carry no event of their own for this responder.
  logic unused_phases;
  assign unused_phases = ^eclk[4:3];

  // Write strobe is the select qualified by the latched direction.
  assign per_we = per_sel & ~rnw_l;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Registered bus outputs, latches and sync timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      vma       <= 1'b0;
      per_sel   <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rnw_l     <= 1'b0;
      per_wdata <= '0;
      rdata     <= '0;
    end else begin
      cnt       <= cnt_n;
      vma       <= vma_n;
      per_sel   <= sel_n;
      ack       <= ack_n;
      err       <= err_n;
      rnw_l     <= rnw_l_n;
      per_wdata <= wdata_n;
      rdata     <= rdata_n;
    end
  end

  // E is registered one cycle after its phase enables: high in phases 6..9.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) e <= 1'b0;
    else       e <= eclk[5] | eclk[6] | eclk[7] | eclk[8];
  end

  // Next-state and next-output decode; the checks within a state are in
  // priority order so overlapping (illegal) phase enables resolve predictably.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    vma_n   = 1'b0;
    sel_n   = 1'b0;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    rnw_l_n = rnw_l;
    wdata_n = per_wdata;
    rdata_n = rdata;
    case (state)
      IDLE: begin
        if (req) begin
          rnw_l_n = rnw;
          wdata_n = wdata;
          // Early in the period there is still time to own this E-high window.
          if (eclk[0] | eclk[1] | eclk[2]) begin
            state_n = WAIT_E;
            vma_n   = 1'b1;
          end else begin
            state_n = SYNC;
            cnt_n   = '0;
          end
        end
      end
      SYNC: begin
        if (!req) begin
          state_n = IDLE;
        end else if (eclk[0]) begin
          state_n = WAIT_E;
          vma_n   = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
          if (cnt_n == TIMEOUT) begin
            err_n   = 1'b1;
            state_n = HOLD;
          end
        end
      end
      WAIT_E: begin
        vma_n = 1'b1;
        if (eclk[5]) begin
          state_n = XFER;
          sel_n   = 1'b1;
        end
      end
      XFER: begin
        if (eclk[9]) begin
          if (rnw_l) rdata_n = per_rdata;
          ack_n   = 1'b1;
          state_n = DONE;
        end else begin
          vma_n = 1'b1;
          sel_n = 1'b1;
        end
      end
      DONE: state_n = HOLD;
      HOLD: begin
        // Requester must drop req for a cycle before a new access starts.
        if (!req) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eclk_bus_bridge.sv
// Bench for eclk_bus_bridge: free-running E phase generator, scoreboard of
// expected acks (cycle and read data), and per-scenario waveform checks.
module tb_eclk_bus_bridge;
  localparam int DATA_W = 8;
  localparam int TO     = 31;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [9:0]        eclk = 10'd1;
  logic              req = 1'b0;
  logic              rnw = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] per_rdata = '0;
  logic              vma, e, per_sel, per_we, ack, err;
  logic [DATA_W-1:0] per_wdata, rdata;

  eclk_bus_bridge #(.DATA_W(DATA_W), .SYNC_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .eclk(eclk), .req(req), .rnw(rnw),
    .wdata(wdata), .per_rdata(per_rdata), .vma(vma), .e(e),
    .per_sel(per_sel), .per_we(per_we), .per_wdata(per_wdata),
    .rdata(rdata), .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int ph = 0;
  bit run = 1'b1;
  int checks = 0;
  int passes = 0;

  typedef struct {
    bit          rd;
    logic [7:0]  data;
    int          due;
  } exp_t;
  exp_t q[$];

  // Phase generator: eclk[ph] one-hot, period 10, freezable for the timeout case.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (run) ph = (ph + 1) % 10;
      eclk = run ? (10'd1 << ph) : 10'd0;
    end
  end

  // Scoreboard consumer: every ack must match the oldest expected transaction.
  always @(negedge clk) begin
    exp_t x;
    if (!reset) begin
      if (ack || err) begin
        checks++;
        if (ack && err) $display("FAIL ack_err_together cycle %0d", cyc);
        else passes++;
      end
      if (ack) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_ack at cycle %0d, none expected", cyc);
        end else begin
          passes++;
          x = q.pop_front();
          checks++;
          if (cyc !== x.due) $display("FAIL ack_cycle got %0d expected %0d", cyc, x.due);
          else passes++;
          if (x.rd) begin
            checks++;
            if (rdata !== x.data) $display("FAIL rdata got %h expected %h", rdata, x.data);
            else passes++;
          end
        end
      end
    end
  end

  task automatic push(input bit rd, input logic [7:0] d, input int lat);
    exp_t x;
    x.rd = rd; x.data = d; x.due = cyc + lat;
    q.push_back(x);
  endtask

  task automatic wait_ph(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ph != p && n < 40);
    if (ph != p) begin
      checks++;
      $display("FAIL wait_phase got %0d expected %0d", ph, p);
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      $display("FAIL drain pending %0d expected 0", q.size());
      q.delete();
    end else passes++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({vma, e, per_sel, per_we, ack, err} !== 6'b0)
      $display("FAIL reset_ctrl got %b expected 000000", {vma, e, per_sel, per_we, ack, err});
    else passes++;
    checks++;
    if (per_wdata !== 8'h00) $display("FAIL reset_per_wdata got %h expected 00", per_wdata);
    else passes++;
    checks++;
    if (rdata !== 8'h00) $display("FAIL reset_rdata got %h expected 00", rdata);
    else passes++;
    reset = 1'b0;
  endtask

  task automatic test_read();
    int vbad = 0, sbad = 0, ebad = 0, wbad = 0, ecnt = 0;
    wait_ph(1);
    rnw = 1'b1; per_rdata = 8'hA5; req = 1'b1;
    push(1'b1, 8'hA5, 9);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (vma !== 1'b1) vbad++;
      if (per_sel !== (ph >= 6)) sbad++;
      if (e !== (ph >= 6)) ebad++;
      if (per_we !== 1'b0) wbad++;
    end
    @(negedge clk);
    req = 1'b0;
    if (vma !== 1'b0 || per_sel !== 1'b0) vbad++;
    checks++;
    if (vbad != 0) $display("FAIL read_vma bad cycles %0d expected 0", vbad); else passes++;
    checks++;
    if (sbad != 0) $display("FAIL read_per_sel bad cycles %0d expected 0", sbad); else passes++;
    checks++;
    if (ebad != 0) $display("FAIL read_e bad cycles %0d expected 0", ebad); else passes++;
    checks++;
    if (wbad != 0) $display("FAIL read_per_we bad cycles %0d expected 0", wbad); else passes++;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (e) ecnt++;
    end
    checks++;
    if (ecnt != 8) $display("FAIL e_duty got %0d high of 20 expected 8", ecnt); else passes++;
  endtask

  task automatic test_write();
    int vbad = 0, wbad = 0, dbad = 0;
    wait_ph(4);
    rnw = 1'b0; wdata = 8'h3C; req = 1'b1;
    push(1'b0, 8'h00, 16);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (vma !== (k >= 7)) vbad++;
      if (per_we !== (k >= 12) || per_sel !== (k >= 12)) wbad++;
      if (k >= 12 && per_wdata !== 8'h3C) dbad++;
      if (k == 8) wdata = 8'hFF;
    end
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (vbad != 0) $display("FAIL write_vma bad cycles %0d expected 0", vbad); else passes++;
    checks++;
    if (wbad != 0) $display("FAIL write_per_we bad cycles %0d expected 0", wbad); else passes++;
    checks++;
    if (dbad != 0) $display("FAIL write_per_wdata bad cycles %0d expected 0", dbad); else passes++;
  endtask

  task automatic test_sync_drop();
    int bad = 0;
    wait_ph(5);
    rnw = 1'b1; req = 1'b1;
    repeat (2) @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (vma || per_sel) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL sync_drop_activity got %0d cycles expected 0", bad); else passes++;
  endtask

  task automatic test_drop_in_xfer();
    int bad = 0;
    wait_ph(1);
    rnw = 1'b1; per_rdata = 8'h5A; req = 1'b1;
    push(1'b1, 8'h5A, 9);
    repeat (6) @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    if (vma !== 1'b0) bad++;
    checks++;
    if (bad != 0) $display("FAIL hold_vma got 1 expected 0"); else passes++;
    @(negedge clk);
    per_rdata = 8'hC3; req = 1'b1;
    push(1'b1, 8'hC3, 8);
    drain(20);
    req = 1'b0;
  endtask

  task automatic test_timeout();
    int c, first = -1, errs = 0, vbad = 0;
    wait_ph(4);
    run = 1'b0; rnw = 1'b1; req = 1'b1;
    c = cyc;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (err) begin
        errs++;
        if (first < 0) first = cyc - c;
      end
      if (vma) vbad++;
    end
    checks++;
    if (first != TO + 1) $display("FAIL timeout_err_cycle got %0d expected %0d", first, TO + 1);
    else passes++;
    checks++;
    if (errs != 1) $display("FAIL timeout_err_width got %0d expected 1", errs); else passes++;
    checks++;
    if (vbad != 0) $display("FAIL timeout_vma got %0d cycles expected 0", vbad); else passes++;
    req = 1'b0; run = 1'b1;
    repeat (3) @(negedge clk);
    wait_ph(0);
    rnw = 1'b0; wdata = 8'h11; req = 1'b1;
    push(1'b0, 8'h00, 10);
    drain(30);
    req = 1'b0;
  endtask

  task automatic test_reset_mid_xfer();
    wait_ph(1);
    rnw = 1'b1; per_rdata = 8'h9C; req = 1'b1;
    push(1'b1, 8'h9C, 9);
    wait_ph(7);
    reset = 1'b1;
    #1;
    checks++;
    if ({vma, per_sel, e, ack} !== 4'b0)
      $display("FAIL reset_mid_xfer got %b expected 0000", {vma, per_sel, e, ack});
    else passes++;
    checks++;
    if (rdata !== 8'h00) $display("FAIL reset_mid_rdata got %h expected 00", rdata); else passes++;
    q.delete(q.size() - 1);
    req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_ph(0);
    per_rdata = 8'h77; req = 1'b1;
    push(1'b1, 8'h77, 10);
    drain(30);
    req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    repeat (3) @(negedge clk);
    test_write();
    repeat (3) @(negedge clk);
    test_sync_drop();
    test_drop_in_xfer();
    repeat (3) @(negedge clk);
    test_timeout();
    repeat (3) @(negedge clk);
    test_reset_mid_xfer();
    checks++;
    if (q.size() != 0) $display("FAIL final_queue pending %0d expected 0", q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
